// File: rtl/slp_pkg.sv
// Shared types for the serial logic processor: function codes, route codes, FSM states.
package slp_pkg;

  typedef enum logic [2:0] {
    FUNC_AND  = 3'b000,
    FUNC_OR   = 3'b001,
    FUNC_XOR  = 3'b010,
    FUNC_ONE  = 3'b011,
    FUNC_NAND = 3'b100,
    FUNC_NOR  = 3'b101,
    FUNC_XNOR = 3'b110,
    FUNC_ZERO = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    ROUTE_KEEP = 2'b00,
    ROUTE_B_F  = 2'b01,
    ROUTE_A_F  = 2'b10,
    ROUTE_SWAP = 2'b11
  } route_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10,
    HOLD  = 2'b11
  } state_e;

  function automatic logic apply_func(input func_e f, input logic a, input logic b);
    logic res;
    case (f)
      FUNC_AND:  res = a & b;
      FUNC_OR:   res = a | b;
      FUNC_XOR:  res = a ^ b;
      FUNC_ONE:  res = 1'b1;
      FUNC_NAND: res = ~(a & b);
      FUNC_NOR:  res = ~(a | b);
      FUNC_XNOR: res = ~(a ^ b);
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/slp_control.sv
// Control FSM for the serial logic processor: Start edge detect, shift counter,
// Busy/Done and the F/R/Dir latches. Dir exists only when SLP_DIR_EN is defined.
module slp_control
  import slp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] f,
  input  logic [1:0] r,
`ifdef SLP_DIR_EN
  input  logic       dir,
`endif
  output logic       busy,
  output logic       done,
  output logic       shift_en,
  output logic       idle,
  output func_e      f_lat,
  output route_e     r_lat,
  output logic       dir_lat
);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic             seen_low;
  logic             dir_in;

`ifdef SLP_DIR_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  assign shift_en = (state == SHIFT);
  assign idle     = (state == IDLE);

  // seen_low records that Start was low at the previous edge; it clears on reset so
  // a Start held high through reset cannot launch an operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      f_lat    <= FUNC_AND;
      r_lat    <= ROUTE_KEEP;
      dir_lat  <= 1'b0;
      seen_low <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      seen_low <= ~start;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start && seen_low) begin
            state   <= SHIFT;
            count   <= CNT_W'(WIDTH);
            f_lat   <= func_e'(f);
            r_lat   <= route_e'(r);
            dir_lat <= dir_in;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= start ? HOLD : IDLE;
        HOLD: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_logic_processor_n.sv
// Parametrised serial logic processor: two shift registers combined bit-serially by F,
// routed by R. Define SLP_DIR_EN to add the Dir port for left shifting.
module serial_logic_processor_n
  import slp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Start,
`ifdef SLP_DIR_EN
  input  logic             Dir,
`endif
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       F,
  input  logic [1:0]       R,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B
);

  logic   shift_en;
  logic   idle;
  func_e  f_lat;
  route_e r_lat;
  logic   dir_lat;
  logic   out_a;
  logic   out_b;
  logic   fval;
  logic   new_a;
  logic   new_b;

  slp_control #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_control (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .start    (Start),
    .f        (F),
    .r        (R),
`ifdef SLP_DIR_EN
    .dir      (Dir),
`endif
    .busy     (Busy),
    .done     (Done),
    .shift_en (shift_en),
    .idle     (idle),
    .f_lat    (f_lat),
    .r_lat    (r_lat),
    .dir_lat  (dir_lat)
  );

  // The outgoing bit is the end the registers shift away from.
  always_comb begin
    out_a = dir_lat ? A[WIDTH-1] : A[0];
    out_b = dir_lat ? B[WIDTH-1] : B[0];
    fval  = apply_func(f_lat, out_a, out_b);
    new_a = out_a;
    new_b = out_b;
    case (r_lat)
      ROUTE_B_F: new_b = fval;
      ROUTE_A_F: new_a = fval;
      ROUTE_SWAP: begin
        new_a = out_b;
        new_b = out_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      A <= '0;
      B <= '0;
    end else if (shift_en) begin
      if (dir_lat) begin
        A <= {A[WIDTH-2:0], new_a};
        B <= {B[WIDTH-2:0], new_b};
      end else begin
        A <= {new_a, A[WIDTH-1:1]};
        B <= {new_b, B[WIDTH-1:1]};
      end
    end else if (idle) begin
      if (LoadA) A <= Din;
      if (LoadB) B <= Din;
    end
  end

endmodule

// File: tb/tb_serial_logic_processor_n.sv
// Self-checking bench for serial_logic_processor_n: a transaction-level model checked
// every cycle, plus directed operations with hand-computed results.
module tb_serial_logic_processor_n;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_a;
  logic         load_b;
  logic         start;
  logic         dir;
  logic [W-1:0] din;
  logic [2:0]   f;
  logic [1:0]   r;
  logic         busy;
  logic         done;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_logic_processor_n #(.WIDTH(W)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .LoadA   (load_a),
    .LoadB   (load_b),
    .Start   (start),
`ifdef SLP_DIR_EN
    .Dir     (dir),
`endif
    .Din     (din),
    .F       (f),
    .R       (r),
    .Busy    (busy),
    .Done    (done),
    .A       (a_out),
    .B       (b_out)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Whole-operation result: W bit-serial steps computed with plain arithmetic.
  function automatic logic [2*W-1:0] op_result(input logic [W-1:0] a0, input logic [W-1:0] b0,
                                               input logic [2:0] fs, input logic [1:0] rs, input logic d);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic x, y, fv, na, nb;
    a = a0;
    b = b0;
    for (int i = 0; i < W; i++) begin
      x = d ? a[W-1] : a[0];
      y = d ? b[W-1] : b[0];
      case (fs[1:0])
        2'd0:    fv = x & y;
        2'd1:    fv = x | y;
        2'd2:    fv = x ^ y;
        default: fv = 1'b1;
      endcase
      if (fs[2]) fv = ~fv;
      case (rs)
        2'd0:    begin na = x;  nb = y;  end
        2'd1:    begin na = x;  nb = fv; end
        2'd2:    begin na = fv; nb = y;  end
        default: begin na = y;  nb = x;  end
      endcase
      if (d) begin
        a = (a << 1) | W'(na);
        b = (b << 1) | W'(nb);
      end else begin
        a = (a >> 1) | (W'(na) << (W - 1));
        b = (b >> 1) | (W'(nb) << (W - 1));
      end
    end
    return {a, b};
  endfunction

  // Model: an operation is "engaged" from launch until Start is released after Done.
  logic [W-1:0] m_a = '0, m_b = '0, m_res_a = '0, m_res_b = '0;
  logic [W-1:0] ld_a, ld_b;
  int           m_left = 0;
  logic         m_done = 1'b0, m_engaged = 1'b0, m_prev_low = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_left <= 0;
      m_done <= 1'b0; m_engaged <= 1'b0; m_prev_low <= 1'b0;
    end else begin
      m_prev_low <= ~start;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_a    <= m_res_a;
          m_b    <= m_res_b;
        end
      end else if (m_done) begin
        m_done    <= 1'b0;
        m_engaged <= start;
      end else if (m_engaged) begin
        if (!start) m_engaged <= 1'b0;
      end else begin
        ld_a = load_a ? din : m_a;
        ld_b = load_b ? din : m_b;
        m_a <= ld_a;
        m_b <= ld_b;
        if (start && m_prev_low) begin
          {m_res_a, m_res_b} <= op_result(ld_a, ld_b, f, r, dir);
          m_left    <= W;
          m_engaged <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check_output("busy", busy, m_left > 0);
    check_output("done", done, m_done);
    if (m_left == 0) begin
      check_output("reg_a", a_out, m_a);
      check_output("reg_b", b_out, m_b);
    end
  end

  task automatic load_regs(input logic [W-1:0] va, input logic [W-1:0] vb);
    load_a = 1'b1; din = va;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b1; din = vb;
    @(negedge clk);
    load_b = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [2:0] fs, input logic [1:0] rs, output int bc, output int dc);
    bc = 0;
    dc = 0;
    f = fs;
    r = rs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W + 6; i++) begin
      if (busy) bc++;
      if (done) dc++;
      @(negedge clk);
    end
  endtask

  logic [W-1:0] and_table [8] = '{8'h11, 8'h77, 8'h66, 8'hFF, 8'hEE, 8'h88, 8'h99, 8'h00};

  initial begin
    int bc, dc;
    rst_n = 1'b0; load_a = 1'b0; load_b = 1'b0; start = 1'b0; dir = 1'b0;
    din = '0; f = '0; r = '0;
    repeat (2) @(negedge clk);
    check_output("reset_a", a_out, 0);
    check_output("reset_b", b_out, 0);
    check_output("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    load_regs(8'h33, 8'h55);
    apply_stimulus(3'b000, 2'b10, bc, dc);
    check_output("t1_busy_cycles", bc, W);
    check_output("t1_done_pulses", dc, 1);
    check_output("t1_a", a_out, 8'h11);
    check_output("t1_b", b_out, 8'h55);

    load_regs(8'h0F, 8'hFF);
    apply_stimulus(3'b010, 2'b01, bc, dc);
    check_output("t2_a", a_out, 8'h0F);
    check_output("t2_b", b_out, 8'hF0);
    load_regs(8'h0F, 8'hFF);
    apply_stimulus(3'b010, 2'b00, bc, dc);
    check_output("t2_keep_a", a_out, 8'h0F);
    check_output("t2_keep_b", b_out, 8'hFF);

    for (int k = 0; k < 8; k++) begin
      load_regs(8'h33, 8'h55);
      apply_stimulus(3'(k), 2'b10, bc, dc);
      check_output($sformatf("func%0d_a", k), a_out, and_table[k]);
    end

    load_regs(8'hA5, 8'h3C);
    f = 3'b000; r = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    f = 3'b101; r = 2'b00; load_a = 1'b1; din = 8'hFF;
    repeat (3) @(negedge clk);
    load_a = 1'b0;
    repeat (W + 2) @(negedge clk);
    check_output("t3_swap_a", a_out, 8'h3C);
    check_output("t3_swap_b", b_out, 8'hA5);

    f = 3'b000; r = 2'b11; start = 1'b1;
    dc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    check_output("hold_done_pulses", dc, 1);
    check_output("hold_busy", busy, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_output("hold_a", a_out, 8'hA5);
    check_output("hold_b", b_out, 8'h3C);

    start = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check_output("start_high_reset_busy", bc, 0);
    start = 1'b0;
    @(negedge clk);

    load_regs(8'h33, 8'h55);
    f = 3'b000; r = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("midreset_a", a_out, 0);
    check_output("midreset_b", b_out, 0);
    check_output("midreset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    check_output("midreset_no_done", dc, 0);
    load_regs(8'h33, 8'h55);
    apply_stimulus(3'b000, 2'b10, bc, dc);
    check_output("after_reset_a", a_out, 8'h11);
    check_output("after_reset_done", dc, 1);

`ifdef SLP_DIR_EN
    run_dir16();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

`ifdef SLP_DIR_EN
  logic        l16a = 1'b0, l16b = 1'b0, s16 = 1'b0, d16 = 1'b0, busy16, done16;
  logic [15:0] din16 = '0, a16, b16;
  logic [2:0]  f16 = '0;
  logic [1:0]  r16 = '0;

  serial_logic_processor_n #(.WIDTH(16)) dut16 (
    .Clk (clk), .Reset_n (rst_n), .LoadA (l16a), .LoadB (l16b), .Start (s16),
    .Dir (d16), .Din (din16), .F (f16), .R (r16),
    .Busy (busy16), .Done (done16), .A (a16), .B (b16)
  );

  task automatic run_dir16();
    int bc16, dc16;
    l16a = 1'b1; din16 = 16'h8001;
    @(negedge clk);
    l16a = 1'b0; l16b = 1'b1; din16 = 16'hFFFF;
    @(negedge clk);
    l16b = 1'b0; f16 = 3'b000; r16 = 2'b10; d16 = 1'b1; s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    bc16 = 0;
    dc16 = 0;
    for (int i = 0; i < 22; i++) begin
      if (busy16) bc16++;
      if (done16) dc16++;
      @(negedge clk);
    end
    check_output("dir16_busy_cycles", bc16, 16);
    check_output("dir16_done_pulses", dc16, 1);
    check_output("dir16_a", a16, 16'h8001);
    check_output("dir16_b", b16, 16'hFFFF);
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
